// File: rtl/pulse_stretcher_if.sv
// Trigger/length request and stretched-level status of a pulse stretcher.
interface pulse_stretcher_if #(
  parameter int unsigned CNT_W = 16
);
  logic             trig_in;
  logic [CNT_W-1:0] len_in;
  logic             level_out;
  logic             busy;
  logic             done;
  logic             missed;

  modport master (
    output trig_in, len_in,
    input  level_out, busy, done, missed
  );

  modport slave (
    input  trig_in, len_in,
    output level_out, busy, done, missed
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle trigger events into a registered level of programmable length,
// with optional retrigger, forced-low holdoff, and done/missed reporting.
module pulse_stretcher #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_LEN = 10,
  parameter int unsigned RETRIGGER   = 1,
  parameter int unsigned GAP         = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  pulse_stretcher_if.slave  bus
);

  if (DEFAULT_LEN < 1) begin : g_bad_default_len
    $error("pulse_stretcher: DEFAULT_LEN must be at least 1");
  end

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StActive  = 2'd1;
  localparam logic [1:0] StHoldoff = 2'd2;

  localparam int unsigned      GapW    = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GapW-1:0]  GapLoad = GapW'(GAP);
  localparam logic [CNT_W-1:0] DefLen  = CNT_W'(DEFAULT_LEN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             missed_q, missed_d;
  logic [CNT_W-1:0] eff_len;

  assign eff_len = (bus.len_in == '0) ? DefLen : bus.len_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    level_d  = level_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    missed_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.trig_in) begin
          state_d = StActive;
          cnt_d   = eff_len;
          level_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StActive: begin
        if (bus.trig_in && (RETRIGGER != 0)) begin
          // Reload wins over expiry, so the level never glitches low.
          cnt_d = eff_len;
        end else begin
          missed_d = bus.trig_in;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            level_d = 1'b0;
            done_d  = 1'b1;
            if (GAP > 0) begin
              state_d = StHoldoff;
              gap_d   = GapLoad;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StHoldoff: begin
        missed_d = bus.trig_in;
        if (gap_q <= GapW'(1)) begin
          state_d = StIdle;
          gap_d   = '0;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        gap_d   = '0;
        level_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      gap_q    <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.missed    = missed_q;

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses, such as edge-detector or debouncer outputs, into a clean level of programmable length.
- Drives LEDs, buzzers and other human-visible indicators in the button/UI path.
- Supports an optional retrigger mode and a mandatory low gap between output pulses.
- Reports completion (done) and dropped events (missed).

Parameters:
CNT_W, 16, width of the length counter and len_in
DEFAULT_LEN, 10, stretch length in cycles used when len_in == 0
RETRIGGER, 1, 1 = a trigger while active reloads the length; 0 = the trigger is ignored and flagged missed
GAP, 0, number of forced-low holdoff cycles after each pulse ends (0 = no holdoff)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
trig_in  input  1  trigger event, sampled every clk; each high cycle counts as one event
len_in  input  CNT_W  stretch length in cycles, sampled only in the cycle a trigger is accepted
level_out  output  1  stretched level, registered
busy  output  1  high in ACTIVE or HOLDOFF, registered
done  output  1  one-cycle pulse in the first cycle level_out is low after a pulse
missed  output  1  one-cycle pulse, registered, in the cycle after a trigger was rejected

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- On reset assertion, immediately and regardless of state:
  - state = IDLE, counter = 0;
  - level_out, busy, done and missed all = 0.
- Effective length: L = (len_in == 0) ? DEFAULT_LEN : len_in.
  - DEFAULT_LEN must be ≥ 1; violating this is a parameter error.
- FSM states: IDLE, ACTIVE, HOLDOFF.
- IDLE:
  - trig_in = 1 in cycle t: load counter = L, go to ACTIVE.
  - level_out and busy are high from cycle t+1.
- ACTIVE:
  - level_out stays high for exactly L consecutive cycles, t+1 .. t+L. The counter decrements each cycle.
  - On the last high cycle: go to HOLDOFF if GAP > 0, else IDLE.
  - done = 1 and level_out = 0 in cycle t+L+1.
- Retrigger, RETRIGGER = 1:
  - trig_in = 1 in an ACTIVE cycle r reloads counter with L sampled at r.
  - level_out then stays high through cycle r+L with no low glitch.
  - No done is produced for the interrupted pulse.
  - trig_in held high continuously keeps level_out high until L cycles after trig_in falls.
- No retrigger, RETRIGGER = 0:
  - trig_in = 1 during ACTIVE is ignored; missed = 1 in the following cycle.
  - The counter is unaffected.
- HOLDOFF:
  - Lasts exactly GAP cycles, starting with the done cycle. level_out = 0, busy = 1.
  - Triggers are ignored, each producing a missed pulse one cycle later.
  - After GAP cycles go to IDLE; busy = 0.
- GAP = 0:
  - A trigger in the done cycle (state IDLE) is accepted.
  - level_out therefore has at least one low cycle between pulses when RETRIGGER = 0, or when a trigger arrives exactly at expiry.
- Simultaneous end-of-pulse and trigger in the last ACTIVE cycle:
  - RETRIGGER = 1: the retrigger wins; the pulse continues and there is no done.
  - RETRIGGER = 0: missed.
- Width rules:
  - The counter is CNT_W bits, with no wrap: it stops at 0.
  - len_in = 2^CNT_W − 1 gives the maximum pulse length.
- Glitch freedom: outputs are pure flop outputs with no combinational path from trig_in.
- Reset mid-pulse: level_out drops asynchronously with no done pulse. The first trigger after release behaves as from IDLE.

Test Plan:
- Basic pulse: defaults, len_in = 5, trig_in high 1 cycle at t=10 -> level_out high cycles 11..15; done = 1 at 16; busy low at 16; missed never.
- Zero length: len_in = 0, single trigger -> level_out high exactly 10 cycles (DEFAULT_LEN); done one cycle after.
- Retrigger:
  - RETRIGGER = 1, len_in = 4, triggers at t=0 and t=3 -> level_out high 1..7 continuous; single done at 8.
  - RETRIGGER = 0, same stimulus -> high 1..4; missed at 4; done at 5.
- Holdoff: GAP = 3, len_in = 2, trigger at 0 -> high 1..2, done at 3.
  - A trigger at 4 gives missed at 5.
  - busy falls at 6; a trigger at 6 gives high 7..8.
- Reset mid-operation: len_in = 20, trigger at 0, reset_n low at 7 (asynchronously, mid-cycle) -> level_out and busy 0 immediately, no done.
  - After release, a trigger gives a full 20-cycle pulse.
- Held trigger: RETRIGGER = 1, len_in = 3, trig_in high cycles 0..9 -> level_out high 1..12; done at 13; missed never asserted.
